// File: rtl/cpu6502_pkg.sv
// Shared 6502 definitions: vector selects, T-state bit indices and the
// two-cycle opcode predecode used by both the sequencer and the decoder.
package cpu6502_pkg;

    localparam logic [1:0] VEC_IRQ = 2'd0;  // FFFE, also BRK
    localparam logic [1:0] VEC_NMI = 2'd1;  // FFFA
    localparam logic [1:0] VEC_RST = 2'd2;  // FFFC

    localparam int T0 = 0;
    localparam int T1 = 1;
    localparam int T2 = 2;

    typedef enum logic [1:0] {
        GRP_NONE,
        GRP_RST,
        GRP_NMI,
        GRP_IRQ
    } grp_e;

    // Opcodes that finish in two cycles and therefore overlap T0 with T2.
    function automatic logic two_cycle(input logic [7:0] op, input logic take_branch);
        return (op[7] && (op[4:2] == 3'b000) && !op[0])
            || (op[4:2] == 3'b010)
            || ((op[4:2] == 3'b110) && !op[0])
            || ((op[4:0] == 5'b10000) && !take_branch);
    endfunction

endpackage

// File: rtl/int_latch.sv
// NMI falling-edge detector and IRQ level sampler feeding the BRK injection
// logic of the timing-state sequencer.
module int_latch (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_nmi_n,
    input  logic i_irq_n,
    input  logic i_irq_sample,
    input  logic i_nmi_clr,
    output logic o_nmi_pend,
    output logic o_irq_lvl
);

    logic r_nmi_d1;
    logic r_nmi_d2;
    logic r_nmi_pend;
    logic r_irq_lvl;
    logic w_nmi_fall;

    assign w_nmi_fall = r_nmi_d2 && !r_nmi_d1;

    // The edge history runs every cycle, even through rdy stalls; a new edge
    // in the same cycle as a clear keeps the request pending.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_nmi_d1   <= 1'b1;
            r_nmi_d2   <= 1'b1;
            r_nmi_pend <= 1'b0;
            r_irq_lvl  <= 1'b0;
        end else begin
            r_nmi_d1 <= i_nmi_n;
            r_nmi_d2 <= r_nmi_d1;
            if (w_nmi_fall) begin
                r_nmi_pend <= 1'b1;
            end else if (i_nmi_clr) begin
                r_nmi_pend <= 1'b0;
            end
            if (i_irq_sample) begin
                r_irq_lvl <= !i_irq_n;
            end
        end
    end

    assign o_nmi_pend = r_nmi_pend;
    assign o_irq_lvl  = r_irq_lvl;

endmodule

// File: rtl/tstate_seq.sv
// 6502 timing-state sequencer and instruction register front end, including
// rdy stalls and BRK injection for reset, NMI and IRQ.
module tstate_seq
    import cpu6502_pkg::*;
#(
    parameter int TW         = 7,
    parameter int RST_CYCLES = 2
) (
    input  logic          clk_m1,
    input  logic          rst_n,
    input  logic          rdy,
    input  logic          wr_cycle_i,
    input  logic [7:0]    data_i,
    input  logic          take_branch_i,
    input  logic          t0next_i,
    input  logic          i_flag_i,
    input  logic          nmi_n_i,
    input  logic          irq_n_i,
    output logic [TW-1:0] tstate,
    output logic          sync,
    output logic [7:0]    ir,
    output logic          rstg,
    output logic          nmig,
    output logic          irqg,
    output logic [1:0]    vec_sel,
    output logic          seq_err
);

    logic [TW-1:0] r_tstate;
    logic [7:0]    r_ir;
    logic          r_rstg;
    logic          r_nmig;
    logic          r_irqg;
    logic [1:0]    r_vec_sel;
    logic          r_seq_err;
    logic          r_rst_pend;
    logic [3:0]    r_hold;

    logic          w_advance;
    logic          w_sync;
    logic          w_load;
    logic          w_nmi_pend;
    logic          w_irq_lvl;
    logic          w_inject;
    logic [7:0]    w_ir_in;
    logic          w_two_cycle;
    grp_e          w_grp;
    logic [TW-1:0] w_tstate_next;
    logic          w_seq_err_next;

    int_latch u_int_latch (
        .i_clk        (clk_m1),
        .i_rst_n      (rst_n),
        .i_nmi_n      (nmi_n_i),
        .i_irq_n      (irq_n_i),
        .i_irq_sample (w_advance && r_tstate[T0]),
        .i_nmi_clr    (w_load && (w_grp == GRP_NMI)),
        .o_nmi_pend   (w_nmi_pend),
        .o_irq_lvl    (w_irq_lvl)
    );

    assign w_advance   = (rdy || wr_cycle_i) && (r_hold == 4'd0);
    assign w_sync      = r_tstate[T1];
    assign w_load      = w_sync && w_advance;
    assign w_inject    = r_rst_pend || w_nmi_pend || (w_irq_lvl && !i_flag_i);
    assign w_ir_in     = w_inject ? 8'h00 : data_i;
    assign w_two_cycle = two_cycle(w_ir_in, take_branch_i);

    always_comb begin
        w_grp = GRP_NONE;
        if (r_rst_pend) begin
            w_grp = GRP_RST;
        end else if (w_nmi_pend) begin
            w_grp = GRP_NMI;
        end else if (w_irq_lvl && !i_flag_i) begin
            w_grp = GRP_IRQ;
        end
    end

    // Running off the top of the vector without a t0next is a decoder bug;
    // recover to T0 and flag it rather than wedging with an all-zero state.
    always_comb begin
        w_tstate_next  = r_tstate;
        w_seq_err_next = 1'b0;
        if (w_advance) begin
            if (w_sync && w_two_cycle) begin
                w_tstate_next     = '0;
                w_tstate_next[T0] = 1'b1;
                w_tstate_next[T2] = 1'b1;
            end else if (t0next_i) begin
                w_tstate_next     = '0;
                w_tstate_next[T0] = 1'b1;
            end else if (r_tstate[TW-1]) begin
                w_tstate_next     = '0;
                w_tstate_next[T0] = 1'b1;
                w_seq_err_next    = 1'b1;
            end else begin
                w_tstate_next = r_tstate << 1;
            end
        end
    end

    always_ff @(posedge clk_m1 or negedge rst_n) begin
        if (!rst_n) begin
            r_tstate     <= '0;
            r_tstate[T0] <= 1'b1;
            r_ir         <= 8'h00;
            r_rstg       <= 1'b1;
            r_nmig       <= 1'b0;
            r_irqg       <= 1'b0;
            r_vec_sel    <= VEC_RST;
            r_seq_err    <= 1'b0;
            r_rst_pend   <= 1'b1;
            r_hold       <= 4'(RST_CYCLES);
        end else begin
            r_seq_err <= w_seq_err_next;
            if (r_hold != 4'd0) begin
                r_hold <= r_hold - 4'd1;
            end
            if (w_advance) begin
                r_tstate <= w_tstate_next;
            end
            if (w_load) begin
                r_ir   <= w_ir_in;
                r_rstg <= (w_grp == GRP_RST);
                r_nmig <= (w_grp == GRP_NMI);
                r_irqg <= (w_grp == GRP_IRQ);
                unique case (w_grp)
                    GRP_RST: r_vec_sel <= VEC_RST;
                    GRP_NMI: r_vec_sel <= VEC_NMI;
                    default: r_vec_sel <= VEC_IRQ;
                endcase
                if (w_grp == GRP_RST) begin
                    r_rst_pend <= 1'b0;
                end
            end
        end
    end

    assign tstate  = r_tstate;
    assign sync    = r_tstate[T1];
    assign ir      = r_ir;
    assign rstg    = r_rstg;
    assign nmig    = r_nmig;
    assign irqg    = r_irqg;
    assign vec_sel = r_vec_sel;
    assign seq_err = r_seq_err;

endmodule

// File: tb/tb_tstate_seq.sv
// Self-checking bench for tstate_seq: a vector table for reset, two-cycle
// predecode and overflow, then hand-written interrupt, stall and reset sequences.
module tb_tstate_seq;

    typedef struct packed {
        logic       rdy;
        logic       wr;
        logic [7:0] data;
        logic       tb;
        logic       t0n;
        logic       iflag;
        logic       nmiN;
        logic       irqN;
    } in_t;

    typedef struct packed {
        logic [6:0] ts;
        logic       sync;
        logic [7:0] ir;
        logic       rstg;
        logic       nmig;
        logic       irqg;
        logic [1:0] vec;
        logic       err;
    } out_t;

    typedef struct packed {
        in_t  in;
        out_t exp;
    } vec_t;

    logic       clk_m1 = 1'b0;
    logic       rst_n = 1'b1;
    logic       rdy = 1'b1;
    logic       wr_cycle_i = 1'b0;
    logic [7:0] data_i = 8'hEA;
    logic       take_branch_i = 1'b0;
    logic       t0next_i = 1'b0;
    logic       i_flag_i = 1'b1;
    logic       nmi_n_i = 1'b1;
    logic       irq_n_i = 1'b1;
    logic [6:0] tstate;
    logic       sync;
    logic [7:0] ir;
    logic       rstg;
    logic       nmig;
    logic       irqg;
    logic [1:0] vec_sel;
    logic       seq_err;

    int    assertCount = 0;
    int    failCount = 0;
    out_t  sbQ[$];
    string nameQ[$];
    vec_t  tbl[$];

    tstate_seq #(.TW(7), .RST_CYCLES(2)) dut (
        .clk_m1        (clk_m1),
        .rst_n         (rst_n),
        .rdy           (rdy),
        .wr_cycle_i    (wr_cycle_i),
        .data_i        (data_i),
        .take_branch_i (take_branch_i),
        .t0next_i      (t0next_i),
        .i_flag_i      (i_flag_i),
        .nmi_n_i       (nmi_n_i),
        .irq_n_i       (irq_n_i),
        .tstate        (tstate),
        .sync          (sync),
        .ir            (ir),
        .rstg          (rstg),
        .nmig          (nmig),
        .irqg          (irqg),
        .vec_sel       (vec_sel),
        .seq_err       (seq_err)
    );

    always #5 clk_m1 = ~clk_m1;

    function automatic in_t mkIn(input logic r, input logic w, input logic [7:0] d,
                                 input logic tb, input logic t0n, input logic iflag,
                                 input logic nmiN, input logic irqN);
        return {r, w, d, tb, t0n, iflag, nmiN, irqN};
    endfunction

    // sync is tstate[1] by definition, so it is filled in from the expected tstate.
    function automatic out_t mkOut(input logic [6:0] ts, input logic [7:0] irv,
                                   input logic rg, input logic ng, input logic ig,
                                   input logic [1:0] vs, input logic er);
        return {ts, ts[1], irv, rg, ng, ig, vs, er};
    endfunction

    task automatic checkOutput();
        out_t  exp;
        out_t  act;
        string nm;
        assertCount++;
        if (sbQ.size() == 0 || nameQ.size() == 0) begin
            failCount++;
            $display("[TB] FAIL scoreboard: got empty queue, expected a pending entry");
        end else begin
            exp = sbQ.pop_front();
            nm  = nameQ.pop_front();
            act = {tstate, sync, ir, rstg, nmig, irqg, vec_sel, seq_err};
            if (act !== exp) begin
                failCount++;
                $display("[TB] FAIL %s: got ts=%b sync=%b ir=%h r/n/i=%b%b%b vec=%0d err=%b, expected ts=%b sync=%b ir=%h r/n/i=%b%b%b vec=%0d err=%b",
                         nm, act.ts, act.sync, act.ir, act.rstg, act.nmig, act.irqg, act.vec, act.err,
                         exp.ts, exp.sync, exp.ir, exp.rstg, exp.nmig, exp.irqg, exp.vec, exp.err);
            end
        end
    endtask

    task automatic applyStimulus(input in_t in, input out_t exp, input string nm);
        rdy           = in.rdy;
        wr_cycle_i    = in.wr;
        data_i        = in.data;
        take_branch_i = in.tb;
        t0next_i      = in.t0n;
        i_flag_i      = in.iflag;
        nmi_n_i       = in.nmiN;
        irq_n_i       = in.irqN;
        sbQ.push_back(exp);
        nameQ.push_back(nm);
        @(posedge clk_m1);
        #1;
        checkOutput();
    endtask

    task automatic expectNow(input out_t exp, input string nm);
        sbQ.push_back(exp);
        nameQ.push_back(nm);
        checkOutput();
    endtask

    initial begin
        // Reset/idle, two-cycle predecode and overflow, as one continuous run.
        tbl.push_back({mkIn(1,0,8'hEA,0,0,1,1,1), mkOut(7'h01,8'h00,1,0,0,2,0)});
        tbl.push_back({mkIn(1,0,8'hEA,0,0,1,1,1), mkOut(7'h01,8'h00,1,0,0,2,0)});
        tbl.push_back({mkIn(1,0,8'hEA,0,0,1,1,1), mkOut(7'h02,8'h00,1,0,0,2,0)});
        tbl.push_back({mkIn(1,0,8'hEA,0,0,1,1,1), mkOut(7'h04,8'h00,1,0,0,2,0)});
        tbl.push_back({mkIn(1,0,8'hEA,0,1,1,1,1), mkOut(7'h01,8'h00,1,0,0,2,0)});
        tbl.push_back({mkIn(1,0,8'hEA,0,0,1,1,1), mkOut(7'h02,8'h00,1,0,0,2,0)});
        tbl.push_back({mkIn(1,0,8'hEA,0,0,1,1,1), mkOut(7'h05,8'hEA,0,0,0,0,0)});
        tbl.push_back({mkIn(1,0,8'hEA,0,1,1,1,1), mkOut(7'h01,8'hEA,0,0,0,0,0)});
        tbl.push_back({mkIn(1,0,8'hEA,0,0,1,1,1), mkOut(7'h02,8'hEA,0,0,0,0,0)});
        tbl.push_back({mkIn(1,0,8'hA9,0,0,1,1,1), mkOut(7'h05,8'hA9,0,0,0,0,0)});
        tbl.push_back({mkIn(1,0,8'hEA,0,1,1,1,1), mkOut(7'h01,8'hA9,0,0,0,0,0)});
        tbl.push_back({mkIn(1,0,8'hEA,0,0,1,1,1), mkOut(7'h02,8'hA9,0,0,0,0,0)});
        tbl.push_back({mkIn(1,0,8'hD0,0,0,1,1,1), mkOut(7'h05,8'hD0,0,0,0,0,0)});
        tbl.push_back({mkIn(1,0,8'hEA,0,1,1,1,1), mkOut(7'h01,8'hD0,0,0,0,0,0)});
        tbl.push_back({mkIn(1,0,8'hEA,0,0,1,1,1), mkOut(7'h02,8'hD0,0,0,0,0,0)});
        tbl.push_back({mkIn(1,0,8'hD0,1,0,1,1,1), mkOut(7'h04,8'hD0,0,0,0,0,0)});
        tbl.push_back({mkIn(1,0,8'hEA,0,0,1,1,1), mkOut(7'h08,8'hD0,0,0,0,0,0)});
        tbl.push_back({mkIn(1,0,8'hEA,0,0,1,1,1), mkOut(7'h10,8'hD0,0,0,0,0,0)});
        tbl.push_back({mkIn(1,0,8'hEA,0,0,1,1,1), mkOut(7'h20,8'hD0,0,0,0,0,0)});
        tbl.push_back({mkIn(1,0,8'hEA,0,0,1,1,1), mkOut(7'h40,8'hD0,0,0,0,0,0)});
        tbl.push_back({mkIn(1,0,8'hEA,0,0,1,1,1), mkOut(7'h01,8'hD0,0,0,0,0,1)});

        #2 rst_n = 1'b0;
        #1 expectNow(mkOut(7'h01,8'h00,1,0,0,2,0), "resetState");
        repeat (2) @(posedge clk_m1);
        #1 rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].in, tbl[i].exp, $sformatf("vec%0d", i));
        end

        // NMI beats IRQ, IRQ follows, then IRQ masked by I.
        applyStimulus(mkIn(1,0,8'hEA,0,1,1,0,1), mkOut(7'h01,8'hD0,0,0,0,0,0), "nmiFall");
        applyStimulus(mkIn(1,0,8'hEA,0,0,0,0,0), mkOut(7'h02,8'hD0,0,0,0,0,0), "irqSample");
        applyStimulus(mkIn(1,0,8'hEA,0,0,0,0,0), mkOut(7'h04,8'h00,0,1,0,1,0), "nmiInject");
        applyStimulus(mkIn(1,0,8'hEA,0,1,0,0,0), mkOut(7'h01,8'h00,0,1,0,1,0), "nmiT0");
        applyStimulus(mkIn(1,0,8'hEA,0,0,0,0,0), mkOut(7'h02,8'h00,0,1,0,1,0), "nmiT1");
        applyStimulus(mkIn(1,0,8'hEA,0,0,0,0,0), mkOut(7'h04,8'h00,0,0,1,0,0), "irqInject");
        applyStimulus(mkIn(1,0,8'hEA,0,1,1,0,0), mkOut(7'h01,8'h00,0,0,1,0,0), "irqT0");
        applyStimulus(mkIn(1,0,8'hEA,0,0,1,0,0), mkOut(7'h02,8'h00,0,0,1,0,0), "irqT1");
        applyStimulus(mkIn(1,0,8'hEA,0,0,1,1,0), mkOut(7'h05,8'hEA,0,0,0,0,0), "irqMasked");
        applyStimulus(mkIn(1,0,8'hEA,0,1,1,1,1), mkOut(7'h01,8'hEA,0,0,0,0,0), "maskedT0");

        // rdy stall at T2 and at sync; NMI edge during the stall still lands.
        applyStimulus(mkIn(1,0,8'hEA,0,0,1,1,1), mkOut(7'h02,8'hEA,0,0,0,0,0), "stallT1");
        applyStimulus(mkIn(1,0,8'hD0,1,0,1,1,1), mkOut(7'h04,8'hD0,0,0,0,0,0), "branchTaken");
        applyStimulus(mkIn(0,0,8'hEA,0,0,1,0,1), mkOut(7'h04,8'hD0,0,0,0,0,0), "stall1");
        applyStimulus(mkIn(0,0,8'hEA,0,0,1,0,1), mkOut(7'h04,8'hD0,0,0,0,0,0), "stall2");
        applyStimulus(mkIn(0,0,8'hEA,0,0,1,0,1), mkOut(7'h04,8'hD0,0,0,0,0,0), "stall3");
        applyStimulus(mkIn(1,0,8'hEA,0,1,1,0,1), mkOut(7'h01,8'hD0,0,0,0,0,0), "stallT0");
        applyStimulus(mkIn(1,0,8'hEA,0,0,1,0,1), mkOut(7'h02,8'hD0,0,0,0,0,0), "stallSync");
        applyStimulus(mkIn(0,0,8'hEA,0,0,1,0,1), mkOut(7'h02,8'hD0,0,0,0,0,0), "syncStall");
        applyStimulus(mkIn(1,0,8'hEA,0,0,1,1,1), mkOut(7'h04,8'h00,0,1,0,1,0), "nmiAfterStall");
        applyStimulus(mkIn(0,1,8'hEA,0,0,1,1,1), mkOut(7'h08,8'h00,0,1,0,1,0), "wrAdvance");

        // Build up pending NMI and IRQ, then reset asynchronously at T3.
        applyStimulus(mkIn(1,0,8'hEA,0,1,1,1,0), mkOut(7'h01,8'h00,0,1,0,1,0), "preRstT0");
        applyStimulus(mkIn(1,0,8'hEA,0,0,1,1,0), mkOut(7'h02,8'h00,0,1,0,1,0), "preRstT1");
        applyStimulus(mkIn(1,0,8'hD0,1,0,1,0,0), mkOut(7'h04,8'hD0,0,0,0,0,0), "preRstLoad");
        applyStimulus(mkIn(1,0,8'hEA,0,0,1,0,0), mkOut(7'h08,8'hD0,0,0,0,0,0), "preRstT3");
        rst_n    = 1'b0;
        nmi_n_i  = 1'b1;
        irq_n_i  = 1'b1;
        i_flag_i = 1'b0;
        #1 expectNow(mkOut(7'h01,8'h00,1,0,0,2,0), "asyncReset");
        #3 rst_n = 1'b1;
        applyStimulus(mkIn(1,0,8'hEA,0,0,0,1,1), mkOut(7'h01,8'h00,1,0,0,2,0), "reHold1");
        applyStimulus(mkIn(1,0,8'hEA,0,0,0,1,1), mkOut(7'h01,8'h00,1,0,0,2,0), "reHold2");
        applyStimulus(mkIn(1,0,8'hEA,0,0,0,1,1), mkOut(7'h02,8'h00,1,0,0,2,0), "reT1");
        applyStimulus(mkIn(1,0,8'hEA,0,0,0,1,1), mkOut(7'h04,8'h00,1,0,0,2,0), "reRstLoad");
        applyStimulus(mkIn(1,0,8'hEA,0,1,0,1,1), mkOut(7'h01,8'h00,1,0,0,2,0), "reT0");
        applyStimulus(mkIn(1,0,8'hEA,0,0,0,1,1), mkOut(7'h02,8'h00,1,0,0,2,0), "reSync");
        applyStimulus(mkIn(1,0,8'hEA,0,0,0,1,1), mkOut(7'h05,8'hEA,0,0,0,0,0), "pendDropped");

        if (sbQ.size() != 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL scoreboardDrain: got %0d entries left, expected 0", sbQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/tstate_seq.md
# tstate_seq

Parametrised timing-state sequencer and instruction-register front end for the 6502 core. It generates the one-hot T-state vector and `sync`, loads `ir` from the opcode fetch, and predecodes two-cycle opcodes into the T0+T2 overlap. It also stalls on `rdy` and injects BRK (00) for reset, NMI and IRQ with priority and group flags. It sits between the bus interface and the opcode decoder, and replaces the inline T-state/IR logic in the control block.

## Interface
- `TW`, default 7: T-state vector width (T0..T(TW-1)); legal range 3..8.
- `RST_CYCLES`, default 2: cycles held in T0 after `rst_n` deasserts before sequencing starts; legal range 0..15.
- `clk_m1` in 1: the only clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `rdy` in 1: bus ready; low stalls read cycles.
- `wr_cycle_i` in 1: current cycle is a bus write; `rdy` is ignored this cycle.
- `data_i` in 8: bus data; opcode byte when `sync`=1.
- `take_branch_i` in 1: branch condition for the opcode on `data_i`.
- `t0next_i` in 1: decoder indicates the next cycle is T0.
- `i_flag_i` in 1: status I bit; masks IRQ.
- `nmi_n_i` in 1: NMI, falling-edge sensitive.
- `irq_n_i` in 1: IRQ, level, active-low.
- `tstate` out TW: one-hot (or T0|T2 overlap) timing state.
- `sync` out 1: equals `tstate[1]`; current cycle is the opcode fetch.
- `ir` out 8: instruction register.
- `rstg`, `nmig`, `irqg` out 1 each: the injected instruction in `ir` serves reset, NMI or IRQ.
- `vec_sel` out 2: vector select; 0 = FFFE (IRQ/BRK), 1 = FFFA (NMI), 2 = FFFC (reset).
- `seq_err` out 1: one-cycle pulse when the T-state overflows.

## Operation
- An advance occurs when `rdy` is 1 or `wr_cycle_i` is 1, and the hold counter is 0. If no advance occurs, all state holds except the NMI edge latch.
- `ir_in` is 8'h00 if an injection is pending at `sync`; otherwise it is `data_i`.
- `two_cycle` is true when any of these hold:
  - `ir_in[7]`=1, `ir_in[4:2]`=000 and `ir_in[0]`=0;
  - `ir_in[4:0]`=010xx;
  - `ir_in[4:0]`=110x0;
  - `ir_in[4:0]`=10000 and `take_branch_i`=0.
- Next-state priority on advance:
  - `sync` and `two_cycle`: next = T0|T2 (bits 0 and 2).
  - else `t0next_i`: next = T0.
  - else if `tstate[TW-1]` is set: next = T0 and `seq_err` pulses.
  - else next = `tstate` << 1.
- IR load: on `sync` with advance, `ir` <= `ir_in`.
- Injection pending means `rst_pend`, `nmi_pend`, or (`irq_lvl` and not `i_flag_i`).
- On an injecting load:
  - Exactly one group flag is set, with priority reset > NMI > IRQ.
  - `vec_sel` is set to match that flag.
  - The corresponding pending bit clears; `irq_lvl` is not cleared, since it is a level.
- On a non-injecting load: all group flags clear and `vec_sel` = 0.
- NMI edge:
  - A two-flop history of `nmi_n_i` detects a 1→0 transition and sets `nmi_pend`.
  - This is evaluated every cycle, including stalls.
  - If a set and a clear occur in the same cycle, set wins and `nmi_pend` stays 1.
- IRQ: `irq_lvl` <= !`irq_n_i`, sampled only on advance while `tstate[0]`.
- Reset (`rst_n` low, asynchronous):
  - `tstate` = T0, `ir` = 00, `rstg` = 1, `vec_sel` = 2.
  - `rst_pend` = 1, `nmi_pend` = 0, `irq_lvl` = 0.
  - `seq_err` = 0, hold counter = `RST_CYCLES`.
  - Reset asserted mid-instruction aborts it immediately; no partial state survives.
- Hold counter: decrements by 1 per cycle while nonzero. `tstate` remains T0 during the hold.

## Timing
- `tstate`, `ir`, group flags and `vec_sel` are registered; `sync` and `seq_err` are derived from registers with no combinational path from inputs.
- `two_cycle` is combinational from `data_i`/`take_branch_i`. It is consumed in the same cycle as `sync`.
- NMI latency: an edge on cycle n is pending at n+2 and is injected at the first `sync` advance from n+2 onward.
- IRQ is recognised only if `irq_n_i` is low at the T0 advance preceding `sync`.
- `rdy` low during `sync` with `wr_cycle_i`=0: `ir` and `tstate` hold and injection is deferred. The same opcode reloads when `rdy` rises.

## Structure
- The shared package (`cpu6502_pkg`) holds the `vec_sel` encodings `VEC_IRQ`, `VEC_NMI`, `VEC_RST`, the T-state bit indices `T0`/`T1`/`T2`, and the `two_cycle` predecode function, which is shared with the decoder.
- One sub-module, `int_latch`: NMI edge detector plus IRQ level sampler, with pending outputs and a clear input.

## Test plan
- Reset then idle, with `RST_CYCLES`=2 and `data_i`=EA:
  - T0 is held for 2 cycles, then T1.
  - The first load gives `ir`=00, `rstg`=1, `vec_sel`=2.
  - The next `sync` loads EA and clears `rstg`.
- Two-cycle paths:
  - `sync` with `data_i`=A9 → next `tstate`=0b0000101.
  - `data_i`=D0 with `take_branch_i`=0 → 0b0000101.
  - `data_i`=D0 with `take_branch_i`=1 → 0b0000100.
- NMI vs IRQ: `nmi_n_i` falls and `irq_n_i`=0 with `i_flag_i`=0, both before T0 → `nmig`=1, `vec_sel`=1. The following instruction gets `irqg`=1. With `i_flag_i`=1, no IRQ injection occurs.
- `rdy` stall: `rdy`=0 for 3 cycles at T2 → `tstate` is frozen. An NMI edge during the stall is still latched and injected at the next `sync`.
- Overflow: `t0next_i` is never asserted with TW=7 → after T6 the next state is T0 and `seq_err` is 1 for exactly one cycle.
- Mid-instruction reset at T3: `rst_n` is pulsed low for half a cycle → `tstate`=1 and `ir`=00 immediately (asynchronously). Pending NMI and IRQ are dropped.
